scratch_req_seq: RTL and testbench

- Bus-master sequencer directly upstream of the 128-bit scratchpad memory.
- Accepts one tagged read/write request at a time on a valid/ready interface and issues a single classic Wishbone cycle (cti=000) to the scratchpad.
- Waits for ack, or times out, then enforces the ack-drain gap the scratchpad's delay-line ack needs, and returns a tagged response.
- Sits between the core's load/store unit and the scratchpad slave.

---
 rtl/scratch_seq_pkg.sv | 39 +++
 rtl/scratch_req_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_scratch_req_seq.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scratch_seq_pkg.sv
// ---------------------------------------------------------------------------
// scratch_seq_pkg
// Shared types and constants for the scratchpad request sequencer.
//   state_e      : sequencer FSM states (idle / bus cycle / response)
//   ERR_*        : resp_err codes returned with every response
//   CTI_CLASSIC  : Wishbone cycle type identifier for a classic cycle
//   req_t        : one captured load/store request
//   in_window()  : window decode helper (upper 14 address bits vs base)
// ---------------------------------------------------------------------------
package scratch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_WIN = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    typedef struct packed {
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  adr;
        logic [127:0] dat;
        logic [7:0]   tag;
    } req_t;

    // The scratchpad decodes only the low 18 address bits, so the upper
    // 14 bits alone decide whether the request targets this window.
    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] base);
        return adr[31:18] == base[31:18];
    endfunction

endpackage

// File: rtl/scratch_req_seq.sv
// ---------------------------------------------------------------------------
// scratch_req_seq
// Bus-master sequencer in front of the 128-bit scratchpad. Takes one tagged
// request at a time, runs a single classic Wishbone cycle, waits for ack or
// times out, enforces an idle gap so stale acks from the slave's delay line
// drain away, and returns a tagged response.
//
// Ports
//   clk_i, rst_i              : clock, synchronous active-high reset
//   req_*                     : request channel (valid/ready handshake)
//   resp_*                    : response channel (valid/ready handshake)
//   cs_o cyc_o stb_o we_o     : Wishbone master controls
//   cti_o sel_o adr_o dat_o   : cycle type, byte lanes, offset, write data
//   bndx_o                    : request tag forwarded to the slave
//   ack_i dat_i bndx_i        : slave ack, read data, returned tag
//
// Optional build macro SCRATCH_REQ_SEQ_PERF_EN adds saturating performance
// counters perf_rd / perf_wr (acked reads / writes) and perf_tmo (timeouts).
// ---------------------------------------------------------------------------
module scratch_req_seq
    import scratch_seq_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'hFFFC0000,
    parameter int unsigned TMO   = 32,
    parameter int unsigned DRAIN = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [15:0]  req_sel,
    input  logic [31:0]  req_adr,
    input  logic [127:0] req_dat,
    input  logic [7:0]   req_tag,

    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_dat,
    output logic [7:0]   resp_tag,
    output logic [1:0]   resp_err,

    output logic         cs_o,
    output logic         cyc_o,
    output logic         stb_o,
    output logic         we_o,
    output logic [2:0]   cti_o,
    output logic [15:0]  sel_o,
    output logic [17:0]  adr_o,
    output logic [127:0] dat_o,
    output logic [7:0]   bndx_o,
    input  logic         ack_i,
    input  logic [127:0] dat_i,
`ifdef SCRATCH_REQ_SEQ_PERF_EN
    output logic [31:0]  perf_rd,
    output logic [31:0]  perf_wr,
    output logic [15:0]  perf_tmo,
`endif
    input  logic [7:0]   bndx_i
);

    localparam int TMO_W   = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int DRAIN_W = $clog2(DRAIN + 1);

    state_e               state_q, state_d;
    req_t                 req_q, req_d;
    logic                 req_ready_q, req_ready_d;
    logic                 bus_q, bus_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [127:0]         resp_dat_q, resp_dat_d;
    logic [7:0]           resp_tag_q, resp_tag_d;
    logic [1:0]           resp_err_q, resp_err_d;

`ifdef SCRATCH_REQ_SEQ_PERF_EN
    logic [31:0]          perf_rd_q, perf_rd_d;
    logic [31:0]          perf_wr_q, perf_wr_d;
    logic [15:0]          perf_tmo_q, perf_tmo_d;
`endif

    // Next-state logic. The drain counter ticks down whenever the bus is
    // idle (ST_RESP and ST_IDLE); it is reloaded only when leaving ST_BUS,
    // because that is the only point where the slave may still have acks
    // in flight. A window miss never touches the bus so it needs no gap.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        bus_d        = bus_q;
        tmo_d        = tmo_q;
        drain_d      = drain_q;
        resp_valid_d = resp_valid_q;
        resp_dat_d   = resp_dat_q;
        resp_tag_d   = resp_tag_q;
        resp_err_d   = resp_err_q;
`ifdef SCRATCH_REQ_SEQ_PERF_EN
        perf_rd_d    = perf_rd_q;
        perf_wr_d    = perf_wr_q;
        perf_tmo_d   = perf_tmo_q;
`endif

        if (state_q != ST_BUS && drain_q != '0) begin
            drain_d = drain_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d.we  = req_we;
                    req_d.sel = req_sel;
                    req_d.adr = req_adr;
                    req_d.dat = req_dat;
                    req_d.tag = req_tag;
                    if (!in_window(req_adr, BASE)) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_WIN;
                        resp_dat_d   = '0;
                        resp_tag_d   = req_tag;
                    end else begin
                        state_d = ST_BUS;
                        bus_d   = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end

            ST_BUS: begin
                // An ack in the final timeout cycle still counts as success.
                if (ack_i) begin
                    state_d      = ST_RESP;
                    bus_d        = 1'b0;
                    drain_d      = DRAIN_W'(DRAIN);
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_OK;
                    resp_dat_d   = req_q.we ? '0 : dat_i;
                    resp_tag_d   = req_q.tag;
`ifdef SCRATCH_REQ_SEQ_PERF_EN
                    if (req_q.we) begin
                        if (perf_wr_q != '1) perf_wr_d = perf_wr_q + 1'b1;
                    end else begin
                        if (perf_rd_q != '1) perf_rd_d = perf_rd_q + 1'b1;
                    end
`endif
                end else if (tmo_q == TMO_W'(TMO - 1)) begin
                    state_d      = ST_RESP;
                    bus_d        = 1'b0;
                    drain_d      = DRAIN_W'(DRAIN);
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TMO;
                    resp_dat_d   = '0;
                    resp_tag_d   = req_q.tag;
`ifdef SCRATCH_REQ_SEQ_PERF_EN
                    if (perf_tmo_q != '1) perf_tmo_d = perf_tmo_q + 1'b1;
`endif
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                bus_d   = 1'b0;
            end
        endcase
    end

    // req_ready is registered from the next state, so a response handshake
    // can never open the request channel in the same cycle.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE) && (drain_d == '0);
    end

    // All sequencer state and every output flop live here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b0;
            bus_q        <= 1'b0;
            tmo_q        <= '0;
            drain_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_dat_q   <= '0;
            resp_tag_q   <= '0;
            resp_err_q   <= '0;
`ifdef SCRATCH_REQ_SEQ_PERF_EN
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_tmo_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            bus_q        <= bus_d;
            tmo_q        <= tmo_d;
            drain_q      <= drain_d;
            resp_valid_q <= resp_valid_d;
            resp_dat_q   <= resp_dat_d;
            resp_tag_q   <= resp_tag_d;
            resp_err_q   <= resp_err_d;
`ifdef SCRATCH_REQ_SEQ_PERF_EN
            perf_rd_q    <= perf_rd_d;
            perf_wr_q    <= perf_wr_d;
            perf_tmo_q   <= perf_tmo_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_dat   = resp_dat_q;
    assign resp_tag   = resp_tag_q;
    assign resp_err   = resp_err_q;

    // cs/cyc/stb always move together for a single classic cycle.
    assign cs_o   = bus_q;
    assign cyc_o  = bus_q;
    assign stb_o  = bus_q;
    assign we_o   = req_q.we;
    assign cti_o  = CTI_CLASSIC;
    assign sel_o  = req_q.sel;
    assign adr_o  = req_q.adr[17:0];
    assign dat_o  = req_q.dat;
    assign bndx_o = req_q.tag;

`ifdef SCRATCH_REQ_SEQ_PERF_EN
    assign perf_rd  = perf_rd_q;
    assign perf_wr  = perf_wr_q;
    assign perf_tmo = perf_tmo_q;
`endif

    // The returned slave tag is informational only and the upper address
    // bits were already consumed by the window decode at accept time.
    logic unused_ok;
    assign unused_ok = ^{bndx_i, req_q.adr[31:18]};

endmodule

// File: tb/tb_scratch_req_seq.sv
// ---------------------------------------------------------------------------
// tb_scratch_req_seq
// Directed bench for scratch_req_seq. A small scratchpad model answers the
// master through a delay line (reads ack 4 cycles after the first sampled
// strobe, writes 2) and keeps acking while the strobe is held, producing the
// trailing stale acks the sequencer must ignore.
// ---------------------------------------------------------------------------
module tb_scratch_req_seq;
    import scratch_seq_pkg::*;

    localparam int unsigned TMO = 32;
    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PARTIAL = {96'h0, 32'hFFFFFFFF};

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [15:0]  req_sel;
    logic [31:0]  req_adr;
    logic [127:0] req_dat;
    logic [7:0]   req_tag;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_dat;
    logic [7:0]   resp_tag;
    logic [1:0]   resp_err;
    logic         cs_o, cyc_o, stb_o, we_o;
    logic [2:0]   cti_o;
    logic [15:0]  sel_o;
    logic [17:0]  adr_o;
    logic [127:0] dat_o;
    logic [7:0]   bndx_o;
    logic         ack_i;
    logic [127:0] dat_i;
    logic [7:0]   bndx_i;
`ifdef SCRATCH_REQ_SEQ_PERF_EN
    logic [31:0]  perf_rd;
    logic [31:0]  perf_wr;
    logic [15:0]  perf_tmo;
`endif

    int check_count = 0;
    int error_count = 0;
    int resp_count  = 0;
    int cyc_cycles  = 0;
    int lat;

    always #5 clk_i = ~clk_i;

    scratch_req_seq #(.BASE(32'hFFFC0000), .TMO(TMO), .DRAIN(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sel(req_sel), .req_adr(req_adr), .req_dat(req_dat),
        .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_dat(resp_dat), .resp_tag(resp_tag), .resp_err(resp_err),
        .cs_o(cs_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .cti_o(cti_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
        .bndx_o(bndx_o), .ack_i(ack_i), .dat_i(dat_i),
`ifdef SCRATCH_REQ_SEQ_PERF_EN
        .perf_rd(perf_rd), .perf_wr(perf_wr), .perf_tmo(perf_tmo),
`endif
        .bndx_i(bndx_i)
    );

    // Scratchpad model: every sampled strobe enters the delay line, so a
    // strobe held for several cycles yields several acks.
    logic [127:0] mem [16];
    logic [3:0]   rd_line;
    logic [1:0]   wr_line;
    logic [127:0] rd_dat_line [4];
    logic [7:0]   tag_line [4];
    logic         slave_mute;
    logic         slave_sel;

    assign slave_sel = cs_o && cyc_o && stb_o && !slave_mute;
    assign ack_i     = rd_line[3] | wr_line[1];
    assign dat_i     = rd_dat_line[3];
    assign bndx_i    = tag_line[3];

    always @(posedge clk_i) begin
        rd_line <= {rd_line[2:0], slave_sel && !we_o};
        wr_line <= {wr_line[0], slave_sel && we_o};
        rd_dat_line[0] <= mem[adr_o[7:4]];
        tag_line[0]    <= bndx_o;
        for (int i = 1; i < 4; i++) begin
            rd_dat_line[i] <= rd_dat_line[i-1];
            tag_line[i]    <= tag_line[i-1];
        end
        if (slave_sel && we_o) begin
            for (int b = 0; b < 16; b++) begin
                if (sel_o[b]) mem[adr_o[7:4]][b*8 +: 8] <= dat_o[b*8 +: 8];
            end
        end
    end

    // Count every response handshake and every cycle the bus is held.
    always @(posedge clk_i) begin
        if (resp_valid && resp_ready) resp_count <= resp_count + 1;
    end

    always @(negedge clk_i) begin
        if (cyc_o) cyc_cycles <= cyc_cycles + 1;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for req_ready, present one request for the accepting
    // edge, and return #1 after that edge.
    task automatic applyStimulus(input logic we, input logic [15:0] sel,
                                 input logic [31:0] adr,
                                 input logic [127:0] dat,
                                 input logic [7:0] tag);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        checkOutput("req_ready_before_accept", {127'h0, req_ready}, 128'h1);
        req_we    = we;
        req_sel   = sel;
        req_adr   = adr;
        req_dat   = dat;
        req_tag   = tag;
        req_valid = 1'b1;
        @(posedge clk_i); #1;
        req_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; latency counts that edge as 1.
    task automatic waitResp(output int latency);
        latency = 1;
        while (!resp_valid && latency < 100) begin
            @(posedge clk_i); #1;
            latency++;
        end
        checkOutput("resp_arrived", {127'h0, resp_valid}, 128'h1);
    endtask

    task automatic consumeResp();
        resp_ready = 1'b1;
        @(posedge clk_i); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rd_line = '0;
        wr_line = '0;
        for (int i = 0; i < 4; i++) begin
            rd_dat_line[i] = '0;
            tag_line[i]    = '0;
        end
        slave_mute = 1'b0;
        rst_i      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_sel    = '0;
        req_adr    = '0;
        req_dat    = '0;
        req_tag    = '0;
        resp_ready = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_req_ready", {127'h0, req_ready}, 128'h0);
        checkOutput("rst_cyc", {127'h0, cyc_o}, 128'h0);
        checkOutput("rst_resp_valid", {127'h0, resp_valid}, 128'h0);
        checkOutput("rst_cti", {125'h0, cti_o}, 128'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("idle_req_ready", {127'h0, req_ready}, 128'h1);

        $display("[TB] full write then read");
        applyStimulus(1'b1, 16'hFFFF, 32'hFFFC0010, D1, 8'd5);
        checkOutput("wr_cyc_next", {127'h0, cyc_o}, 128'h1);
        waitResp(lat);
        checkOutput("wr_lat", 128'(lat), 128'd4);
        checkOutput("wr_err", {126'h0, resp_err}, {126'h0, ERR_OK});
        checkOutput("wr_tag", {120'h0, resp_tag}, 128'd5);
        checkOutput("wr_dat", resp_dat, 128'h0);
        consumeResp();

        applyStimulus(1'b0, 16'hFFFF, 32'hFFFC0010, '0, 8'd6);
        waitResp(lat);
        checkOutput("rd_lat", 128'(lat), 128'd6);
        checkOutput("rd_dat", resp_dat, D1);
        checkOutput("rd_tag", {120'h0, resp_tag}, 128'd6);
        checkOutput("rd_err", {126'h0, resp_err}, {126'h0, ERR_OK});
        consumeResp();
        // Drain was loaded on the ack edge and has 3 more edges to go.
        checkOutput("drain_ready_0", {127'h0, req_ready}, 128'h0);
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("drain_ready_2", {127'h0, req_ready}, 128'h0);
        @(posedge clk_i); #1;
        checkOutput("drain_ready_3", {127'h0, req_ready}, 128'h1);

        $display("[TB] partial write");
        applyStimulus(1'b1, 16'hFFFF, 32'hFFFC0020, '0, 8'd7);
        waitResp(lat);
        consumeResp();
        applyStimulus(1'b1, 16'h000F, 32'hFFFC0020, {128{1'b1}}, 8'd8);
        waitResp(lat);
        consumeResp();
        applyStimulus(1'b0, 16'hFFFF, 32'hFFFC0020, '0, 8'd9);
        waitResp(lat);
        checkOutput("partial_dat", resp_dat, PARTIAL);
        consumeResp();

        $display("[TB] out of window");
        applyStimulus(1'b0, 16'hFFFF, 32'h00000010, '0, 8'd10);
        cyc_cycles = 0;
        waitResp(lat);
        checkOutput("win_lat", 128'(lat), 128'd1);
        checkOutput("win_err", {126'h0, resp_err}, {126'h0, ERR_WIN});
        checkOutput("win_tag", {120'h0, resp_tag}, 128'd10);
        checkOutput("win_dat", resp_dat, 128'h0);
        consumeResp();
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("win_no_cyc", 128'(cyc_cycles), 128'd0);

        $display("[TB] timeout");
        slave_mute = 1'b1;
        cyc_cycles = 0;
        applyStimulus(1'b0, 16'hFFFF, 32'hFFFC0030, '0, 8'd11);
        waitResp(lat);
        checkOutput("tmo_cyc_cycles", 128'(cyc_cycles), 128'(TMO));
        checkOutput("tmo_lat", 128'(lat), 128'(TMO + 1));
        checkOutput("tmo_err", {126'h0, resp_err}, {126'h0, ERR_TMO});
        checkOutput("tmo_dat", resp_dat, 128'h0);
        checkOutput("tmo_tag", {120'h0, resp_tag}, 128'd11);
        consumeResp();
        slave_mute = 1'b0;

        $display("[TB] back to back with stalled consumer");
        applyStimulus(1'b0, 16'hFFFF, 32'hFFFC0010, '0, 8'd12);
        req_we    = 1'b0;
        req_sel   = 16'hFFFF;
        req_adr   = 32'hFFFC0020;
        req_tag   = 8'd13;
        req_valid = 1'b1;
        waitResp(lat);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_hold", {118'h0, resp_valid, resp_tag, req_ready},
                        {118'h0, 1'b1, 8'd12, 1'b0});
            @(posedge clk_i); #1;
        end
        checkOutput("stall_dat", resp_dat, D1);
        consumeResp();
        checkOutput("b2b_released", {126'h0, resp_valid, req_ready}, 128'h1);
        @(posedge clk_i); #1;
        req_valid = 1'b0;
        waitResp(lat);
        checkOutput("b2b_lat", 128'(lat), 128'd6);
        checkOutput("b2b_tag", {120'h0, resp_tag}, 128'd13);
        checkOutput("b2b_dat", resp_dat, PARTIAL);
        consumeResp();
        repeat (10) @(posedge clk_i);
        #1;
        checkOutput("no_stale_resp", {127'h0, resp_valid}, 128'h0);
        checkOutput("resp_count", 128'(resp_count), 128'd9);
`ifdef SCRATCH_REQ_SEQ_PERF_EN
        checkOutput("perf_rd", {96'h0, perf_rd}, 128'd4);
        checkOutput("perf_wr", {96'h0, perf_wr}, 128'd3);
        checkOutput("perf_tmo", {112'h0, perf_tmo}, 128'd1);
`endif

        $display("[TB] reset during bus cycle");
        applyStimulus(1'b0, 16'hFFFF, 32'hFFFC0010, '0, 8'd14);
        checkOutput("rst_bus_cyc_up", {127'h0, cyc_o}, 128'h1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checkOutput("rst_bus_ctrl", {125'h0, cyc_o, cs_o, stb_o}, 128'h0);
        checkOutput("rst_bus_resp", {127'h0, resp_valid}, 128'h0);
        @(posedge clk_i); #1;
        checkOutput("rst_bus_ready", {127'h0, req_ready}, 128'h1);
        repeat (10) @(posedge clk_i);
        #1;
        checkOutput("rst_no_resp", {127'h0, resp_valid}, 128'h0);
        checkOutput("rst_resp_count", 128'(resp_count), 128'd9);

        $display("Simulation finished: %0d checks, %0d errors",
                 check_count, error_count);
        $finish;
    end

endmodule
